// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip add/subtract: one BLOCK-bit skip block is resolved per stage,
// with operand skew, a valid/ready stream interface and registered status flags.
module pipelined_carry_skip_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSTAGE = WIDTH / BLOCK;
    localparam int NMID   = NSTAGE - 1;

    // Returns {carry into block MSB, block carry out, block sum bits}.
    function automatic logic [BLOCK+1:0] blk_resolve(input logic [BLOCK-1:0] p,
                                                     input logic [BLOCK-1:0] g,
                                                     input logic             ci);
        logic             c;
        logic             cm;
        logic [BLOCK-1:0] s;
        c  = ci;
        cm = ci;
        s  = '0;
        for (int i = 0; i < BLOCK; i++) begin
            s[i] = p[i] ^ c;
            cm   = c;
            c    = g[i] | (p[i] & c);
        end
        return {cm, ((&p) ? ci : c), s};
    endfunction

    // Intermediate ranks: word holds resolved sum bits low and raw propagate bits high.
    logic [WIDTH-1:0] wrd_q [NMID];
    logic [WIDTH-1:0] wrd_d [NMID];
    logic [WIDTH-1:0] gen_q [NMID];
    logic [WIDTH-1:0] gen_d [NMID];
    logic             cy_q  [NMID];
    logic             cy_d  [NMID];
    logic             vld_q [NMID];

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             out_valid_q;

    logic             en_s;
    logic [WIDTH-1:0] bx_s;
    logic             c0_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] g_s;
    logic [BLOCK+1:0] r_s;

    assign en_s      = !out_valid_q || out_ready;
    assign in_ready  = en_s;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Operand conditioning and next-state of every stage.
    always_comb begin
        bx_s   = b;
        c0_s   = 1'b0;
        p_s    = '0;
        g_s    = '0;
        r_s    = '0;
        sum_d  = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        zero_d = 1'b0;
        for (int k = 0; k < NMID; k++) begin
            wrd_d[k] = '0;
            gen_d[k] = '0;
            cy_d[k]  = 1'b0;
        end

        case (op)
            2'b00:   begin bx_s = b;  c0_s = 1'b0; end
            2'b01:   begin bx_s = ~b; c0_s = 1'b1; end
            2'b10:   begin bx_s = b;  c0_s = cin;  end
            2'b11:   begin bx_s = ~b; c0_s = cin;  end
            default: begin bx_s = b;  c0_s = 1'b0; end
        endcase

        p_s = a ^ bx_s;
        g_s = a & bx_s;
        r_s = blk_resolve(p_s[BLOCK-1:0], g_s[BLOCK-1:0], c0_s);
        wrd_d[0]             = p_s;
        wrd_d[0][BLOCK-1:0]  = r_s[BLOCK-1:0];
        gen_d[0]             = g_s;
        cy_d[0]              = r_s[BLOCK];

        for (int k = 1; k < NMID; k++) begin
            r_s = blk_resolve(wrd_q[k-1][k*BLOCK +: BLOCK], gen_q[k-1][k*BLOCK +: BLOCK],
                              cy_q[k-1]);
            wrd_d[k]                    = wrd_q[k-1];
            wrd_d[k][k*BLOCK +: BLOCK]  = r_s[BLOCK-1:0];
            gen_d[k]                    = gen_q[k-1];
            cy_d[k]                     = r_s[BLOCK];
        end

        // Final block also produces the MSB carries used by the flags.
        r_s = blk_resolve(wrd_q[NMID-1][NMID*BLOCK +: BLOCK], gen_q[NMID-1][NMID*BLOCK +: BLOCK],
                          cy_q[NMID-1]);
        sum_d                       = wrd_q[NMID-1];
        sum_d[NMID*BLOCK +: BLOCK]  = r_s[BLOCK-1:0];
        cout_d                      = r_s[BLOCK];
        ovf_d                       = r_s[BLOCK+1] ^ r_s[BLOCK];
        zero_d                      = (sum_d == '0);
    end

    // Pipeline registers: everything advances together on en, bubbles included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NMID; k++) begin
                wrd_q[k] <= '0;
                gen_q[k] <= '0;
                cy_q[k]  <= 1'b0;
                vld_q[k] <= 1'b0;
            end
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en_s) begin
            for (int k = 0; k < NMID; k++) begin
                wrd_q[k] <= wrd_d[k];
                gen_q[k] <= gen_d[k];
                cy_q[k]  <= cy_d[k];
            end
            vld_q[0] <= in_valid;
            for (int k = 1; k < NMID; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= vld_q[NMID-1];
        end
    end
endmodule

// File: doc/pipelined_carry_skip_adder.md
Name: pipelined_carry_skip_adder

Overview:
- Parametrised, pipelined successor of the team's 8-bit carry-skip adder.
- Splits a WIDTH-bit add/subtract into BLOCK-bit carry-skip blocks, with one block resolved per pipeline stage.
- Streaming operands use a valid/ready handshake, and results carry status flags.
- Sits between operand sources and the ALU result bus in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of BLOCK, minimum 8.
- BLOCK, 4, skip-block width in bits; also the bits resolved per pipeline stage.
- NSTAGE (localparam), WIDTH/BLOCK, pipeline depth and latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  external carry/borrow-in, used by op 10/11 only.
- op  in  2  00 add, 01 sub, 10 add with cin, 11 sub with borrow (cin=1 means no borrow).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; for sub this is the no-borrow flag.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset: clk and rst are the only clock and reset; reset is asynchronous and active-high. On reset, every stage valid bit, out_valid, sum, cout, ovf and zero go to 0; in_ready = 1 once rst deasserts.
- Effective operand: bx = b for op 00/10, ~b for op 01/11. Carry-in c0 is:
  - 0 for op 00;
  - 1 for op 01;
  - cin for op 10/11.
- Sampling: a, bx, c0 and the op MSB are captured when in_valid && in_ready.
- Pipeline enable: en = !out_valid || out_ready, applied globally; every stage advances only when en=1. in_ready = en, purely combinational from out_valid/out_ready.
- Stage k (k = 0..NSTAGE-1) resolves bits [k*BLOCK +: BLOCK].
  - Block propagate: Pblk = AND of (a^bx) over the block.
  - Block carry out = Pblk ? block carry-in : ripple-generated carry of the block. This is the skip path.
  - Sum bits = p ^ internal carries.
  - Resolved low bits, unresolved high operand bits and the running carry are registered forward (operand skew). The stage valid bit is registered alongside.
- Latency: a beat accepted in cycle t appears on out_valid/sum at cycle t+NSTAGE if no stall.
- Throughput: one beat per cycle while out_ready=1.
- Flags, registered with the final stage:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (sum == 0).
- Backpressure:
  - When out_valid=1 and out_ready=0, all stages hold and in_ready=0.
  - A held result stays stable: sum/flags do not change until accepted.
  - No bubble collapsing; bubbles in the pipe are held too.
- Simultaneous events:
  - out accept and new input in the same cycle are both taken; the pipe shifts by one.
  - in_valid=0 inserts a bubble (valid bit 0). Bubble datapath contents are don't-care, but out_valid must be 0 for them.
- Wrap-around: results are modulo 2^WIDTH; overflow is reported only via cout/ovf, never saturated.
- Reset mid-operation clears all in-flight beats immediately; no partial result is emitted after release.

Test Plan:
- WIDTH=16, BLOCK=4, op=00, a=0x1234, b=0x4321, out_ready=1 -> 4 cycles later sum=0x5555, cout=0, ovf=0, zero=0.
- Full skip chain: op=00, a=0xFFFF, b=0x0000, then op=10 with cin=1 -> first sum=0xFFFF, cout=0; second sum=0x0000, cout=1, zero=1.
- Subtract/overflow: op=01, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1. Then op=01, a=0x0001, b=0x0002 -> sum=0xFFFF, cout=0, ovf=0.
- Back-to-back stream: 8 consecutive beats, out_ready=1 -> 8 consecutive out_valid cycles in order, starting 4 cycles after the first accept; in_ready stays 1.
- Backpressure: out_ready=0 for 5 cycles while a result is valid -> in_ready=0, sum/flags held. On release, results drain in order with none lost or duplicated.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0 and all outputs 0 immediately (async). After release, a new beat appears after exactly 4 cycles.
